// File: rtl/mc_controller.sv
// Multicycle MIPS-style control FSM: registered state, outputs decoded from state and i_memready.
// Optional JUMP state is compiled in when MC_CONTROLLER_JUMP_EN is defined.
module mc_controller (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [5:0] i_op,
    input  logic       i_memready,
    output logic       o_pcwrite,
    output logic       o_irwrite,
    output logic       o_regwrite,
    output logic       o_memwrite,
    output logic       o_branch,
    output logic       o_iord,
    output logic       o_alusrca,
    output logic       o_regdst,
    output logic       o_memtoreg,
    output logic [1:0] o_alusrcb,
    output logic [1:0] o_pcsrc,
    output logic [1:0] o_aluop,
    output logic       o_illegal,
    output logic [3:0] o_state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_RTYP = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    state_t state_q, state_d;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Fetch enables are gated by reset so a ready memory cannot write while reset is held.
    logic fetch_go;
    assign fetch_go = i_memready & ~i_reset;

    always_comb begin
        state_d    = S_FETCH;
        o_pcwrite  = 1'b0;
        o_irwrite  = 1'b0;
        o_regwrite = 1'b0;
        o_memwrite = 1'b0;
        o_branch   = 1'b0;
        o_iord     = 1'b0;
        o_alusrca  = 1'b0;
        o_regdst   = 1'b0;
        o_memtoreg = 1'b0;
        o_alusrcb  = 2'b00;
        o_pcsrc    = 2'b00;
        o_aluop    = 2'b00;
        o_illegal  = 1'b0;
        case (state_q)
            S_FETCH: begin
                o_alusrcb = 2'b01;
                o_irwrite = fetch_go;
                o_pcwrite = fetch_go;
                state_d   = i_memready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                o_alusrcb = 2'b11;
                case (i_op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYP:      state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
`ifdef MC_CONTROLLER_JUMP_EN
                    OP_J:         state_d = S_JUMP;
`endif
                    default: begin
                        state_d   = S_FETCH;
                        o_illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                o_alusrca = 1'b1;
                o_alusrcb = 2'b10;
                state_d   = (i_op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                o_iord  = 1'b1;
                state_d = i_memready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                o_memtoreg = 1'b1;
                o_regwrite = 1'b1;
            end
            S_MEMWR: begin
                o_iord     = 1'b1;
                o_memwrite = 1'b1;
                state_d    = i_memready ? S_FETCH : S_MEMWR;
            end
            S_EXEC: begin
                o_alusrca = 1'b1;
                o_aluop   = 2'b10;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                o_regdst   = 1'b1;
                o_regwrite = 1'b1;
            end
            S_BRANCH: begin
                o_alusrca = 1'b1;
                o_aluop   = 2'b01;
                o_pcsrc   = 2'b01;
                o_branch  = 1'b1;
            end
            S_ADDIEX: begin
                o_alusrca = 1'b1;
                o_alusrcb = 2'b10;
                state_d   = S_ADDIWB;
            end
            S_ADDIWB: begin
                o_regwrite = 1'b1;
            end
`ifdef MC_CONTROLLER_JUMP_EN
            S_JUMP: begin
                o_pcsrc   = 2'b10;
                o_pcwrite = 1'b1;
            end
`endif
            default: state_d = S_FETCH;
        endcase
    end

    assign o_state = state_q;

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: stimulus queues hand-computed per-cycle outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_mc_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] op;
    logic       mr;
    logic       pcwrite, irwrite, regwrite, memwrite, branch;
    logic       iord, alusrca, regdst, memtoreg;
    logic [1:0] alusrcb, pcsrc, aluop;
    logic       illegal;
    logic [3:0] state;

    always #5 clk = ~clk;

    mc_controller dut (
        .i_clk      (clk),
        .i_reset    (rst),
        .i_op       (op),
        .i_memready (mr),
        .o_pcwrite  (pcwrite),
        .o_irwrite  (irwrite),
        .o_regwrite (regwrite),
        .o_memwrite (memwrite),
        .o_branch   (branch),
        .o_iord     (iord),
        .o_alusrca  (alusrca),
        .o_regdst   (regdst),
        .o_memtoreg (memtoreg),
        .o_alusrcb  (alusrcb),
        .o_pcsrc    (pcsrc),
        .o_aluop    (aluop),
        .o_illegal  (illegal),
        .o_state    (state)
    );

    // Packing: {pcwrite,irwrite,regwrite,memwrite,branch}, {iord,alusrca,regdst,memtoreg},
    // alusrcb, pcsrc, aluop, illegal
    localparam logic [15:0] O_FETCH0  = {5'b00000, 4'b0000, 2'b01, 2'b00, 2'b00, 1'b0};
    localparam logic [15:0] O_FETCH1  = {5'b11000, 4'b0000, 2'b01, 2'b00, 2'b00, 1'b0};
    localparam logic [15:0] O_DECODE  = {5'b00000, 4'b0000, 2'b11, 2'b00, 2'b00, 1'b0};
    localparam logic [15:0] O_ILLEGAL = {5'b00000, 4'b0000, 2'b11, 2'b00, 2'b00, 1'b1};
    localparam logic [15:0] O_MEMADR  = {5'b00000, 4'b0100, 2'b10, 2'b00, 2'b00, 1'b0};
    localparam logic [15:0] O_MEMRD   = {5'b00000, 4'b1000, 2'b00, 2'b00, 2'b00, 1'b0};
    localparam logic [15:0] O_MEMWB   = {5'b00100, 4'b0001, 2'b00, 2'b00, 2'b00, 1'b0};
    localparam logic [15:0] O_MEMWR   = {5'b00010, 4'b1000, 2'b00, 2'b00, 2'b00, 1'b0};
    localparam logic [15:0] O_EXEC    = {5'b00000, 4'b0100, 2'b00, 2'b00, 2'b10, 1'b0};
    localparam logic [15:0] O_ALUWB   = {5'b00100, 4'b0010, 2'b00, 2'b00, 2'b00, 1'b0};
    localparam logic [15:0] O_BRANCH  = {5'b00001, 4'b0100, 2'b00, 2'b01, 2'b01, 1'b0};
    localparam logic [15:0] O_ADDIWB  = {5'b00100, 4'b0000, 2'b00, 2'b00, 2'b00, 1'b0};
`ifdef MC_CONTROLLER_JUMP_EN
    localparam logic [15:0] O_JUMP    = {5'b10000, 4'b0000, 2'b00, 2'b10, 2'b00, 1'b0};
`endif

    typedef struct {
        string       name;
        logic [3:0]  st;
        logic [15:0] o;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    logic [15:0] outs;
    assign outs = {pcwrite, irwrite, regwrite, memwrite, branch,
                   iord, alusrca, regdst, memtoreg, alusrcb, pcsrc, aluop, illegal};

    // Monitor: one expected entry per cycle, sampled mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                total++;
                if (state !== e.st) begin
                    bad++;
                    $display("FAIL %s state: got %0d want %0d", e.name, state, e.st);
                end
                total++;
                if (outs !== e.o) begin
                    bad++;
                    $display("FAIL %s outputs: got %b want %b", e.name, outs, e.o);
                end
                $display("cycle %s: state=%0d outs=%b", e.name, state, outs);
            end
        end
    end

    task automatic step(input string name, input logic [5:0] op_v, input logic mr_v,
                        input logic [3:0] st, input logic [15:0] o);
        exp_t e;
        op = op_v;
        mr = mr_v;
        e.name = name;
        e.st   = st;
        e.o    = o;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        op  = 6'b000000;
        mr  = 1'b1;
        @(posedge clk);
        #1;
        step("reset_hold_mr1", 6'b000000, 1'b1, 4'd0, O_FETCH0);
        rst = 1'b0;

        // LW, no waits: 0,1,2,3,4
        step("lw_fetch",  6'b100011, 1'b1, 4'd0, O_FETCH1);
        step("lw_decode", 6'b100011, 1'b1, 4'd1, O_DECODE);
        step("lw_memadr", 6'b100011, 1'b1, 4'd2, O_MEMADR);
        step("lw_memrd",  6'b100011, 1'b1, 4'd3, O_MEMRD);
        step("lw_memwb",  6'b100011, 1'b1, 4'd4, O_MEMWB);

        // SW with three wait cycles in MEMWR
        step("sw_fetch",  6'b101011, 1'b1, 4'd0, O_FETCH1);
        step("sw_decode", 6'b101011, 1'b1, 4'd1, O_DECODE);
        step("sw_memadr", 6'b101011, 1'b1, 4'd2, O_MEMADR);
        step("sw_wait1",  6'b101011, 1'b0, 4'd5, O_MEMWR);
        step("sw_wait2",  6'b101011, 1'b0, 4'd5, O_MEMWR);
        step("sw_wait3",  6'b101011, 1'b0, 4'd5, O_MEMWR);
        step("sw_done",   6'b101011, 1'b1, 4'd5, O_MEMWR);

        // R-type
        step("r_fetch",  6'b000000, 1'b1, 4'd0, O_FETCH1);
        step("r_decode", 6'b000000, 1'b1, 4'd1, O_DECODE);
        step("r_exec",   6'b000000, 1'b1, 4'd6, O_EXEC);
        step("r_aluwb",  6'b000000, 1'b1, 4'd7, O_ALUWB);

        // BEQ
        step("beq_fetch",  6'b000100, 1'b1, 4'd0, O_FETCH1);
        step("beq_decode", 6'b000100, 1'b1, 4'd1, O_DECODE);
        step("beq_branch", 6'b000100, 1'b1, 4'd8, O_BRANCH);

        // ADDI
        step("addi_fetch",  6'b001000, 1'b1, 4'd0, O_FETCH1);
        step("addi_decode", 6'b001000, 1'b1, 4'd1, O_DECODE);
        step("addi_ex",     6'b001000, 1'b1, 4'd9, O_MEMADR);
        step("addi_wb",     6'b001000, 1'b1, 4'd10, O_ADDIWB);

        // Illegal opcode
        step("ill_fetch",  6'b111111, 1'b1, 4'd0, O_FETCH1);
        step("ill_decode", 6'b111111, 1'b1, 4'd1, O_ILLEGAL);

        // Jump
        step("j_fetch", 6'b000010, 1'b1, 4'd0, O_FETCH1);
`ifdef MC_CONTROLLER_JUMP_EN
        step("j_decode", 6'b000010, 1'b1, 4'd1, O_DECODE);
        step("j_jump",   6'b000010, 1'b1, 4'd11, O_JUMP);
`else
        step("j_decode_ill", 6'b000010, 1'b1, 4'd1, O_ILLEGAL);
`endif

        // FETCH waits two cycles, then R-type
        step("fw_wait1",  6'b000000, 1'b0, 4'd0, O_FETCH0);
        step("fw_wait2",  6'b000000, 1'b0, 4'd0, O_FETCH0);
        step("fw_go",     6'b000000, 1'b1, 4'd0, O_FETCH1);
        step("fw_decode", 6'b000000, 1'b1, 4'd1, O_DECODE);
        step("fw_exec",   6'b000000, 1'b1, 4'd6, O_EXEC);
        step("fw_aluwb",  6'b000000, 1'b1, 4'd7, O_ALUWB);

        // LW with one MEMRD wait
        step("lwr_fetch",  6'b100011, 1'b1, 4'd0, O_FETCH1);
        step("lwr_decode", 6'b100011, 1'b1, 4'd1, O_DECODE);
        step("lwr_memadr", 6'b100011, 1'b1, 4'd2, O_MEMADR);
        step("lwr_wait",   6'b100011, 1'b0, 4'd3, O_MEMRD);
        step("lwr_memrd",  6'b100011, 1'b1, 4'd3, O_MEMRD);
        step("lwr_memwb",  6'b100011, 1'b1, 4'd4, O_MEMWB);

        // Reset asserted mid-MEMWR wait, no clock edge in between
        step("rs_fetch",  6'b101011, 1'b1, 4'd0, O_FETCH1);
        step("rs_decode", 6'b101011, 1'b1, 4'd1, O_DECODE);
        step("rs_memadr", 6'b101011, 1'b1, 4'd2, O_MEMADR);
        step("rs_memwr",  6'b101011, 1'b0, 4'd5, O_MEMWR);
        rst = 1'b1;
        step("rs_async",  6'b101011, 1'b0, 4'd0, O_FETCH0);
        step("rs_mr1",    6'b101011, 1'b1, 4'd0, O_FETCH0);
        rst = 1'b0;
        step("rs_fetch2", 6'b000100, 1'b1, 4'd0, O_FETCH1);
        step("rs_decode2",6'b000100, 1'b1, 4'd1, O_DECODE);

        // Let the monitor drain, bounded
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
